// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and constants for the branch resolution stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // funct3 encodings of the conditional branches; 010/011 are illegal
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_op_t;

  // Weakly not-taken
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Fall-through distance for a 32-bit instruction
  localparam int unsigned PC_STEP = 4;

  // 2-bit saturating counter step
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != 2'b11)) begin
      nxt = cnt + 2'd1;
    end else if (!taken && (cnt != 2'b00)) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_history_table
//  Description : Table of 2-bit saturating counters, one combinational read
//                port and one synchronous update port, both indexed by PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic            upd_en_i
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       cnt_q [BHT_ENTRIES];
  logic [1:0]       cnt_d;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_unused_pc_bits;

  // Word-aligned PCs: drop the two byte-offset bits
  assign w_rd_idx  = rd_pc_i[IDX_W+1:2];
  assign w_upd_idx = upd_pc_i[IDX_W+1:2];

  assign w_unused_pc_bits = ^{rd_pc_i[XLEN-1:IDX_W+2], rd_pc_i[1:0],
                              upd_pc_i[XLEN-1:IDX_W+2], upd_pc_i[1:0]};

  // Read sees the registered array, so a same-cycle update is not bypassed
  assign rd_taken_o = cnt_q[w_rd_idx][1];

  // Next value of the counter being trained
  always_comb begin
    cnt_d = bht_next(cnt_q[w_upd_idx], upd_taken_i);
  end

  // Counter storage; every entry starts weakly not-taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt_q[i] <= BHT_RESET;
      end
    end else if (upd_en_i) begin
      cnt_q[w_upd_idx] <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Resolves conditional branches, computes the redirect target,
//                flags mispredictions and trains the branch history table.
//                One registered output stage with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_op,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic             out_illegal,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  output logic [CNT_W-1:0] mispredict_count
);

  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic [XLEN-1:0]  out_target_q, out_target_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic             w_accept;
  logic             w_retire;
  logic             w_taken;
  logic             w_illegal;
  logic             w_eq;
  logic             w_lt_s;
  logic             w_lt_u;
  logic [XLEN-1:0]  w_target;

  // Ready ignores flush so upstream never sees a combinational path from it
  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_retire = out_valid_q && out_ready && !flush;

  assign w_eq   = (in_rs1 == in_rs2);
  assign w_lt_s = ($signed(in_rs1) < $signed(in_rs2));
  assign w_lt_u = (in_rs1 < in_rs2);

  // Branch condition decode; unused funct3 codes never take
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (br_op_t'(in_op))
      BEQ:     w_taken = w_eq;
      BNE:     w_taken = !w_eq;
      BLT:     w_taken = w_lt_s;
      BGE:     w_taken = !w_lt_s;
      BLTU:    w_taken = w_lt_u;
      BGEU:    w_taken = !w_lt_u;
      default: w_illegal = 1'b1;
    endcase
  end

  // Both additions wrap modulo 2^XLEN
  assign w_target = w_taken ? (in_pc + in_imm) : (in_pc + XLEN'(PC_STEP));

  // Output stage next state: flush beats accept, accept beats plain retire
  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_target_d     = out_target_q;
    out_mispredict_d = out_mispredict_q;
    out_illegal_d    = out_illegal_q;
    mis_cnt_d        = mis_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d      = 1'b1;
      out_taken_d      = w_taken;
      out_target_d     = w_target;
      out_mispredict_d = (w_taken != in_pred_taken);
      out_illegal_d    = w_illegal;
    end else if (w_retire) begin
      out_valid_d = 1'b0;
    end
    if (w_retire && out_mispredict_q && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  // Output register and performance counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_target_q     <= '0;
      out_mispredict_q <= 1'b0;
      out_illegal_q    <= 1'b0;
      mis_cnt_q        <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_target_q     <= out_target_d;
      out_mispredict_q <= out_mispredict_d;
      out_illegal_q    <= out_illegal_d;
      mis_cnt_q        <= mis_cnt_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_target       = out_target_q;
  assign out_mispredict   = out_mispredict_q;
  assign out_illegal      = out_illegal_q;
  assign mispredict_count = mis_cnt_q;

  branch_history_table #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .XLEN        (XLEN)
  ) u_bht (
    .clk         (clk),
    .reset       (reset),
    .rd_pc_i     (pred_pc),
    .rd_taken_o  (pred_taken),
    .upd_pc_i    (in_pc),
    .upd_taken_i (w_taken),
    .upd_en_i    (w_accept && !w_illegal)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Self-checking bench for branch_resolve_unit with a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [2:0]  in_op;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_mispredict;
  logic        out_illegal;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [15:0] mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_bht [16];
  bit          m_valid;
  bit          m_taken, m_mis, m_ill;
  logic [31:0] m_target;
  int          m_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_pc            (in_pc),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_imm           (in_imm),
    .in_op            (in_op),
    .in_pred_taken    (in_pred_taken),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_taken        (out_taken),
    .out_target       (out_target),
    .out_mispredict   (out_mispredict),
    .out_illegal      (out_illegal),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  // Branch condition straight from the ISA definition
  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_target = '0; m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [2:0] op,
                       input bit pred, input bit fl, input bit ordy, input logic [31:0] ppc);
    in_valid = v; in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm; in_op = op;
    in_pred_taken = pred; flush = fl; out_ready = ordy; pred_pc = ppc;
  endtask

  // Check everything against the model, clock once, advance the model
  task automatic cycle();
    bit acc, ret, tk, ill;
    logic [31:0] tgt;
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("pred_taken", pred_taken, m_bht[bidx(pred_pc)] >= 2);
    chk("mispredict_count", mispredict_count, m_cnt);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_taken", out_taken, m_taken);
      chk("out_target", out_target, m_target);
      chk("out_mispredict", out_mispredict, m_mis);
      chk("out_illegal", out_illegal, m_ill);
    end
    acc = in_valid && (!m_valid || out_ready) && !flush;
    ret = m_valid && out_ready && !flush;
    tk  = ref_taken(in_op, in_rs1, in_rs2);
    ill = (in_op == 3'd2) || (in_op == 3'd3);
    tgt = tk ? in_pc + in_imm : in_pc + 32'd4;
    @(posedge clk);
    #1;
    if (ret && m_mis && m_cnt < 65535) m_cnt++;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_taken = tk; m_target = tgt; m_mis = (tk != in_pred_taken); m_ill = ill;
    end else if (ret) m_valid = 0;
    if (acc && !ill) begin
      if (tk) m_bht[bidx(in_pc)] = (m_bht[bidx(in_pc)] == 3) ? 3 : m_bht[bidx(in_pc)] + 1;
      else    m_bht[bidx(in_pc)] = (m_bht[bidx(in_pc)] == 0) ? 0 : m_bht[bidx(in_pc)] - 1;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_out_taken", out_taken, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Signed vs unsigned compare of the same operands
    drive(1, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 3'd4, 0, 0, 1, 32'h40);
    cycle();
    chk("blt_taken", out_taken, 1);
    chk("blt_target", out_target, 32'h120);
    chk("blt_mispredict", out_mispredict, 1);
    drive(1, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 3'd6, 0, 0, 1, 32'h40);
    cycle();
    chk("bltu_taken", out_taken, 0);
    chk("bltu_target", out_target, 32'h104);

    // Train the same index taken four times back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40, 32'h5, 32'h5, 32'h8, 3'd0, 1, 0, 1, 32'h40);
      cycle();
      chk("bht_train", pred_taken, 1);
    end

    // Back-pressure: held result must stay put, then retire+load on one edge
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h80 + 32'(i * 4), 32'h1, 32'h2, 32'h10, 3'd1, 0, 0, 0, 32'h80);
      cycle();
    end
    drive(1, 32'h90, 32'h1, 32'h2, 32'h10, 3'd1, 0, 0, 1, 32'h90);
    cycle();
    chk("hold_release_target", out_target, 32'hA0);

    // Flush with a result held and an input offered
    drive(1, 32'h44, 32'h0, 32'h1, 32'h10, 3'd4, 0, 1, 0, 32'h44);
    cycle();
    chk("flush_out_valid", out_valid, 0);

    // Illegal funct3 and PC wrap
    drive(1, 32'h40, 32'h3, 32'h3, 32'h8, 3'd2, 1, 0, 1, 32'h40);
    cycle();
    chk("illegal_flag", out_illegal, 1);
    chk("illegal_taken", out_taken, 0);
    chk("illegal_target", out_target, 32'h44);
    drive(1, 32'hFFFFFFFC, 32'h7, 32'h7, 32'h8, 3'd0, 1, 0, 1, 32'h40);
    cycle();
    chk("wrap_target", out_target, 32'h4);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : a + 32'($urandom_range(0, 3)) - 32'd1);
      drive($urandom_range(0, 3) != 0, {$urandom_range(0, 63), 2'b00} | (($urandom_range(0, 15) == 0) ? 32'hFFFFFF00 : 32'h0),
            a, b, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, {26'd0, 4'($urandom_range(0, 15)), 2'b00});
      cycle();
    end

    // Reset while a result is held
    drive(1, 32'h40, 32'h1, 32'h1, 32'h8, 3'd0, 0, 0, 1, 32'h40);
    cycle();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", mispredict_count, 0);
    chk("midrst_pred_taken", pred_taken, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the RISC-V core. It supersedes the single-bit branch selector. The unit evaluates all six conditional branch types on raw operands, computes the redirect target, and detects mispredictions. It also owns a small 2-bit branch history table (BHT) that fetch queries and that trains on every resolved branch. It sits between execute and the PC-redirect logic, with one registered output stage and valid/ready handshaking on both sides.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2
- CNT_W, 16, width of the misprediction performance counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- in_valid  in  1  branch presented
- in_ready  out  1  unit can accept this cycle
- in_pc  in  XLEN  branch instruction PC
- in_rs1, in_rs2  in  XLEN  source operands
- in_imm  in  XLEN  sign-extended B-immediate
- in_op  in  3  funct3 branch code
- in_pred_taken  in  1  prediction fetch used for this branch
- flush  in  1  kill held result and any same-cycle input
- out_valid  out  1  resolved result held
- out_ready  in  1  consumer accepts result
- out_taken  out  1  branch condition true
- out_target  out  XLEN  correct next PC
- out_mispredict  out  1  out_taken != in_pred_taken of that branch
- out_illegal  out  1  in_op was 010 or 011
- pred_pc  in  XLEN  fetch lookup PC
- pred_taken  out  1  BHT prediction for pred_pc; combinational
- mispredict_count  out  CNT_W  saturating count of mispredicts delivered

## Operation
- in_op decode:
  - 000 BEQ: equal
  - 001 BNE: not equal
  - 100 BLT: signed less-than
  - 101 BGE: signed not-less-than
  - 110 BLTU: unsigned less-than
  - 111 BGEU: unsigned not-less-than
  - 010/011: taken=0 and out_illegal=1; BHT is not updated; mispredict is still evaluated.
- Target:
  - taken: in_pc + in_imm, modulo 2^XLEN (wraps, no overflow flag)
  - not taken: in_pc + 4, modulo 2^XLEN
- Accept: in_valid && in_ready && !flush. On accept the output register loads and out_valid is 1 next cycle.
- in_ready = !out_valid || out_ready, regardless of flush.
- Handshake: result retires on out_valid && out_ready. A simultaneous accept and retire replaces the held result with no bubble.
- Output hold: while out_valid && !out_ready, all out_* fields are stable.
- Flush: out_valid is 0 at the next edge. An input offered in the flush cycle is dropped: no BHT update, no counter update.
- BHT:
  - Index is pc[$clog2(BHT_ENTRIES)+1:2].
  - pred_taken = counter[1].
  - On each legal accept, counters saturate: 00 → 11 on taken, 11 → 00 on not-taken.
  - A lookup and update to the same index in one cycle returns the pre-update value.
- mispredict_count increments when a result with out_mispredict=1 retires. It saturates at all-ones.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 branch/cycle while out_ready=1.
- pred_taken: zero-latency combinational read from pred_pc.
- BHT update is visible to lookups from the edge after the accept.
- Reset values:
  - out_valid=0, out_taken=0, out_target=0, out_mispredict=0, out_illegal=0
  - mispredict_count=0
  - all BHT counters=01 (weakly not-taken), so pred_taken=0
- Reset mid-operation discards the held result with no retire.

## Structure
- Package branch_pkg:
  - br_op_t enum (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - BHT_RESET = 2'b01
  - PC_STEP = 4
- Sub-module branch_history_table, parameterised by BHT_ENTRIES and XLEN. It provides one combinational read port and one synchronous update port (index, taken, en).
- The top level holds the comparators, the target adder, the output register, and the counter.

## Test plan
- Reset, then set pred_pc=0x40 → pred_taken=0. All outputs 0, in_ready=1.
- BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0 → next cycle out_taken=1, target=0x120, mispredict=1. Same operands with BLTU → taken=0, target=0x104.
- Same taken branch at pc=0x40 three times back-to-back, with out_ready=1 → pred_taken(0x40) goes 0→1→1. Counter saturates at 11; a fourth taken branch leaves it at 11.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → held result retires and the new one loads on the same edge.
- Flush while out_valid=1 and in_valid=1 → out_valid=0 next cycle, BHT and mispredict_count unchanged.
- in_op=010 → out_illegal=1, out_taken=0, BHT entry unchanged. Also, pc=0xFFFFFFFC with BEQ taken and imm=8 → target=0x4 (wrap).
